bit_serializer: RTL

Parallel-to-serial stage feeding the serial `in` input of the downstream "101" sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, with a one-entry holding buffer so back-to-back words stream with no idle bits. Idle line level is 0. This keeps the detector free of spurious 1s between frames.

---
 rtl/ser_pkg.sv | 17 +
 rtl/ser_hold_buf.sv | 36 +++
 rtl/bit_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer (parity build selected by SER_PARITY_EN).
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;

  // Callers zero-extend their word, which leaves the XOR unchanged; words up to 64 bits.
  function automatic logic even_par(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer in front of the shifter; owns the registered din_ready.
module ser_hold_buf
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             unload,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             din_ready
);

  logic full_nx;

  // A load on the same edge as an unload refills the slot, so load wins.
  assign full_nx = load | (hold_full & ~unload);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      hold_full <= full_nx;
      din_ready <= ~full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (load) hold <= din;
  end

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial stage with one-word holding buffer.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t       state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             hold_load, hold_unload;
  logic             xfer, last_bit, frame_end;
  logic             load_sh;
  logic [WIDTH-1:0] load_word;
`ifdef SER_PARITY_EN
  logic             par, par_nx;
`endif

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .load      (hold_load),
    .unload    (hold_unload),
    .hold      (hold),
    .hold_full (hold_full),
    .din_ready (din_ready)
  );

  assign xfer     = din_valid & din_ready;
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
`ifdef SER_PARITY_EN
  assign frame_end = (state == PAR);
`else
  assign frame_end = last_bit;
`endif

  always_comb begin
    state_nx    = state;
    sh_nx       = sh;
    cnt_nx      = cnt;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    load_sh     = 1'b0;
    load_word   = din;
`ifdef SER_PARITY_EN
    par_nx      = par;
`endif
    case (state)
      IDLE: if (xfer) load_sh = 1'b1;
      SHIFT:
        if (!last_bit) begin
          sh_nx     = sh << 1;
          cnt_nx    = cnt + CNT_W'(1);
          hold_load = xfer;
        end
`ifdef SER_PARITY_EN
        else begin
          state_nx  = PAR;
          hold_load = xfer;
        end
`endif
      default: ;
    endcase
    // Next word at end of frame: held word first, then a same-edge transfer, else go idle.
    if (frame_end) begin
      if (hold_full) begin
        load_sh     = 1'b1;
        load_word   = hold;
        hold_unload = 1'b1;
        hold_load   = xfer;
      end else if (xfer) begin
        load_sh = 1'b1;
      end else begin
        state_nx = IDLE;
        sh_nx    = '0;
        cnt_nx   = '0;
      end
    end
    if (load_sh) begin
      state_nx = SHIFT;
      sh_nx    = load_word;
      cnt_nx   = '0;
`ifdef SER_PARITY_EN
      par_nx   = even_par(64'(load_word));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      cnt   <= cnt_nx;
`ifdef SER_PARITY_EN
      par   <= par_nx;
`endif
    end
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state)
      SHIFT: begin
        sout       = sh[WIDTH-1];
        sout_valid = 1'b1;
      end
`ifdef SER_PARITY_EN
      PAR: begin
        sout       = par;
        sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != IDLE) || hold_full;

endmodule
